// File: rtl/bp_be_fe_cmd_gen_pkg.sv
// Shared types for the backend-to-frontend command generator: resolve
// classification, frontend branch metadata layout and attaboy queue entry.
package bp_be_fe_cmd_gen_pkg;

    localparam int vaddr_width_gp              = 39;
    localparam int branch_metadata_fwd_width_gp = 16;

    typedef enum logic [1:0] {
        e_none,
        e_attaboy,
        e_redir_br,
        e_redir_nonbr
    } bp_be_resolve_e;

    // Metadata the frontend attaches to each fetched instruction.
    typedef struct packed {
        logic [11:0] bht_idx;
        logic        src_btb;
        logic        is_jalr;
        logic        is_jal;
        logic        is_br;
    } bp_fe_branch_metadata_fwd_s;

    typedef struct packed {
        logic [vaddr_width_gp-1:0]  pc;
        bp_fe_branch_metadata_fwd_s md;
        logic                       taken;
        logic                       ntaken;
    } bp_be_attaboy_entry_s;

    function automatic bp_be_resolve_e resolve_decode(
        input logic mispred,
        input logic ctl
    );
        bp_be_resolve_e kind;
        unique case ({mispred, ctl})
            2'b11:   kind = e_redir_br;
            2'b10:   kind = e_redir_nonbr;
            2'b01:   kind = e_attaboy;
            default: kind = e_none;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/bp_be_fe_cmd_gen_attaboy.sv
// Attaboy FIFO: holds correct-prediction training records until the
// frontend yumis them. Ports: enq_v_i/enq_data_i in, full_o, deq_v_o/deq_data_o/deq_yumi_i out-handshake.
module bp_be_fe_cmd_gen_attaboy
    import bp_be_fe_cmd_gen_pkg::*;
#(
    parameter int els_p = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 enq_v_i,
    input  bp_be_attaboy_entry_s enq_data_i,
    output logic                 full_o,
    output logic                 deq_v_o,
    output bp_be_attaboy_entry_s deq_data_o,
    input  logic                 deq_yumi_i
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = $clog2(els_p + 1);

    bp_be_attaboy_entry_s r_mem [els_p];
    logic [ptr_w-1:0]     r_wptr;
    logic [ptr_w-1:0]     r_rptr;
    logic [cnt_w-1:0]     r_count;
    logic                 w_deq;

    assign full_o     = (r_count == cnt_w'(els_p));
    assign deq_v_o    = (r_count != '0);
    assign w_deq      = deq_yumi_i & deq_v_o;
    assign deq_data_o = r_mem[r_rptr];

    always_ff @(posedge clk_i) begin
        if (enq_v_i) r_mem[r_wptr] <= enq_data_i;
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (enq_v_i) r_wptr <= r_wptr + ptr_w'(1);
            if (w_deq)   r_rptr <= r_rptr + ptr_w'(1);
            unique case ({enq_v_i, w_deq})
                2'b10:   r_count <= r_count + cnt_w'(1);
                2'b01:   r_count <= r_count - cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) deq_yumi_i |-> deq_v_o
    );

endmodule

// File: rtl/bp_be_fe_cmd_gen.sv
// Turns resolved control flow and traps into one-cycle frontend redirects
// or queued attaboys. Ports: resolve_* in (v/ready), trap_* in, redirect_* out, attaboy_* out (v/yumi), perf counters out.
module bp_be_fe_cmd_gen
    import bp_be_fe_cmd_gen_pkg::*;
#(
    parameter int attaboy_els_p = 4,
    parameter int perf_width_p  = 32
) (
    input  logic                                    clk_i,
    input  logic                                    reset_n_i,
    input  logic                                    resolve_v_i,
    output logic                                    resolve_ready_o,
    input  logic [vaddr_width_gp-1:0]               resolve_pc_i,
    input  logic [vaddr_width_gp-1:0]               resolve_npc_i,
    input  logic [vaddr_width_gp-1:0]               resolve_pred_npc_i,
    input  logic                                    resolve_taken_i,
    input  logic [branch_metadata_fwd_width_gp-1:0] resolve_br_metadata_fwd_i,
    input  logic                                    trap_v_i,
    input  logic [vaddr_width_gp-1:0]               trap_pc_i,
    output logic                                    redirect_v_o,
    output logic [vaddr_width_gp-1:0]               redirect_pc_o,
    output logic                                    redirect_br_v_o,
    output logic                                    redirect_taken_o,
    output logic                                    redirect_ntaken_o,
    output logic                                    redirect_nonbr_o,
    output logic [branch_metadata_fwd_width_gp-1:0] redirect_br_metadata_fwd_o,
    output logic                                    attaboy_v_o,
    output logic [vaddr_width_gp-1:0]               attaboy_pc_o,
    output logic [branch_metadata_fwd_width_gp-1:0] attaboy_br_metadata_fwd_o,
    output logic                                    attaboy_taken_o,
    output logic                                    attaboy_ntaken_o,
    input  logic                                    attaboy_yumi_i,
    output logic [perf_width_p-1:0]                 mispredict_cnt_o,
    output logic [perf_width_p-1:0]                 attaboy_cnt_o
);

    localparam logic [perf_width_p-1:0] lp_one = perf_width_p'(1);

    bp_fe_branch_metadata_fwd_s w_md;
    bp_be_resolve_e             w_kind;
    bp_be_attaboy_entry_s       w_enq_data;
    bp_be_attaboy_entry_s       w_head;
    logic w_mispred, w_ctl, w_full, w_accept;
    logic w_enq, w_redir, w_taken, w_ntaken;
    logic w_unused_pc;

    // The resolved pc is only carried for tracing; nothing here needs it.
    assign w_unused_pc = ^resolve_pc_i;

    assign w_md      = resolve_br_metadata_fwd_i;
    assign w_mispred = (resolve_npc_i != resolve_pred_npc_i);
    assign w_ctl     = w_md.is_br | w_md.is_jal | w_md.is_jalr;
    assign w_kind    = resolve_decode(w_mispred, w_ctl);
    assign w_taken   = w_md.is_br ? resolve_taken_i : 1'b1;
    assign w_ntaken  = w_md.is_br & ~resolve_taken_i;

    assign resolve_ready_o = ~w_full;

    // A trap wins: a same-cycle resolve is handshaken away but has no effect.
    assign w_accept = resolve_v_i & ~w_full & ~trap_v_i;
    assign w_enq    = w_accept & (w_kind == e_attaboy);
    assign w_redir  = w_accept & ((w_kind == e_redir_br)
                                | (w_kind == e_redir_nonbr));

    assign w_enq_data = '{pc:     resolve_npc_i,
                          md:     w_md,
                          taken:  w_taken,
                          ntaken: w_ntaken};

    bp_be_fe_cmd_gen_attaboy #(.els_p(attaboy_els_p)) u_queue (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .enq_v_i    (w_enq),
        .enq_data_i (w_enq_data),
        .full_o     (w_full),
        .deq_v_o    (attaboy_v_o),
        .deq_data_o (w_head),
        .deq_yumi_i (attaboy_yumi_i)
    );

    assign attaboy_pc_o              = w_head.pc;
    assign attaboy_br_metadata_fwd_o = w_head.md;
    assign attaboy_taken_o           = w_head.taken;
    assign attaboy_ntaken_o          = w_head.ntaken;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            redirect_v_o               <= 1'b0;
            redirect_pc_o              <= '0;
            redirect_br_v_o            <= 1'b0;
            redirect_taken_o           <= 1'b0;
            redirect_ntaken_o          <= 1'b0;
            redirect_nonbr_o           <= 1'b0;
            redirect_br_metadata_fwd_o <= '0;
        end else begin
            redirect_v_o               <= trap_v_i | w_redir;
            redirect_pc_o              <= '0;
            redirect_br_v_o            <= 1'b0;
            redirect_taken_o           <= 1'b0;
            redirect_ntaken_o          <= 1'b0;
            redirect_nonbr_o           <= 1'b0;
            redirect_br_metadata_fwd_o <= '0;
            if (trap_v_i) begin
                redirect_pc_o <= trap_pc_i;
            end else if (w_redir) begin
                redirect_pc_o              <= resolve_npc_i;
                redirect_br_v_o            <= 1'b1;
                redirect_br_metadata_fwd_o <= w_md;
                if (w_kind == e_redir_nonbr) begin
                    redirect_nonbr_o <= 1'b1;
                end else begin
                    redirect_taken_o  <= w_taken;
                    redirect_ntaken_o <= w_ntaken;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mispredict_cnt_o <= '0;
            attaboy_cnt_o    <= '0;
        end else begin
            if (w_redir && (mispredict_cnt_o != '1))
                mispredict_cnt_o <= mispredict_cnt_o + lp_one;
            if (w_enq && (attaboy_cnt_o != '1))
                attaboy_cnt_o <= attaboy_cnt_o + lp_one;
        end
    end

endmodule

// File: tb/tb_bp_be_fe_cmd_gen.sv
// Directed bench for bp_be_fe_cmd_gen: redirects, traps, attaboy FIFO,
// reset and counter saturation (second instance with 2-bit counters).
module tb_bp_be_fe_cmd_gen;
    import bp_be_fe_cmd_gen_pkg::*;

    typedef logic [vaddr_width_gp-1:0] va_t;
    typedef logic [branch_metadata_fwd_width_gp-1:0] md_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic resolve_v = 1'b0;
    va_t  resolve_pc = '0, resolve_npc = '0, resolve_pred = '0;
    logic resolve_taken = 1'b0;
    md_t  resolve_md = '0;
    logic trap_v = 1'b0;
    va_t  trap_pc = '0;
    logic yumi = 1'b0;

    logic ready, rv, rbr, rtk, rntk, rnb, av, atk, antk;
    va_t  rpc, apc;
    md_t  rmd, amd;
    logic [31:0] mis_cnt, atb_cnt;

    logic s_ready, s_rv, s_rbr, s_rtk, s_rntk, s_rnb, s_av, s_atk, s_antk;
    va_t  s_rpc, s_apc;
    md_t  s_rmd, s_amd;
    logic [1:0] s_mis_cnt, s_atb_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bp_be_fe_cmd_gen #(.attaboy_els_p(4), .perf_width_p(32)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .resolve_v_i(resolve_v), .resolve_ready_o(ready),
        .resolve_pc_i(resolve_pc), .resolve_npc_i(resolve_npc),
        .resolve_pred_npc_i(resolve_pred), .resolve_taken_i(resolve_taken),
        .resolve_br_metadata_fwd_i(resolve_md),
        .trap_v_i(trap_v), .trap_pc_i(trap_pc),
        .redirect_v_o(rv), .redirect_pc_o(rpc), .redirect_br_v_o(rbr),
        .redirect_taken_o(rtk), .redirect_ntaken_o(rntk),
        .redirect_nonbr_o(rnb), .redirect_br_metadata_fwd_o(rmd),
        .attaboy_v_o(av), .attaboy_pc_o(apc),
        .attaboy_br_metadata_fwd_o(amd), .attaboy_taken_o(atk),
        .attaboy_ntaken_o(antk), .attaboy_yumi_i(yumi),
        .mispredict_cnt_o(mis_cnt), .attaboy_cnt_o(atb_cnt)
    );

    bp_be_fe_cmd_gen #(.attaboy_els_p(4), .perf_width_p(2)) dut_sat (
        .clk_i(clk), .reset_n_i(reset_n),
        .resolve_v_i(resolve_v), .resolve_ready_o(s_ready),
        .resolve_pc_i(resolve_pc), .resolve_npc_i(resolve_npc),
        .resolve_pred_npc_i(resolve_pred), .resolve_taken_i(resolve_taken),
        .resolve_br_metadata_fwd_i(resolve_md),
        .trap_v_i(trap_v), .trap_pc_i(trap_pc),
        .redirect_v_o(s_rv), .redirect_pc_o(s_rpc), .redirect_br_v_o(s_rbr),
        .redirect_taken_o(s_rtk), .redirect_ntaken_o(s_rntk),
        .redirect_nonbr_o(s_rnb), .redirect_br_metadata_fwd_o(s_rmd),
        .attaboy_v_o(s_av), .attaboy_pc_o(s_apc),
        .attaboy_br_metadata_fwd_o(s_amd), .attaboy_taken_o(s_atk),
        .attaboy_ntaken_o(s_antk), .attaboy_yumi_i(yumi),
        .mispredict_cnt_o(s_mis_cnt), .attaboy_cnt_o(s_atb_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input va_t pc, input va_t npc, input va_t pred,
                         input logic tk, input md_t md);
        resolve_v = 1'b1;
        resolve_pc = pc;
        resolve_npc = npc;
        resolve_pred = pred;
        resolve_taken = tk;
        resolve_md = md;
    endtask

    task automatic idle();
        resolve_v = 1'b0;
        trap_v = 1'b0;
        yumi = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL reset_redirect_v: got %b want 0", rv); end
        n_cmp++; if (rpc !== va_t'(0)) begin n_bad++; $display("FAIL reset_redirect_pc: got %h want 0", rpc); end
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (av !== 1'b0) begin n_bad++; $display("FAIL reset_attaboy_v: got %b want 0", av); end
        n_cmp++; if (mis_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_mis_cnt: got %0d want 0", mis_cnt); end
        n_cmp++; if (atb_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_atb_cnt: got %0d want 0", atb_cnt); end
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_br_redirect();
        drive(va_t'(32'h1000), va_t'(32'h1040), va_t'(32'h1004), 1'b1, 16'h0AB1);
        step();
        idle();
        n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL br_v_pulse: got %b want 1", rv); end
        n_cmp++; if (rpc !== va_t'(32'h1040)) begin n_bad++; $display("FAIL br_pc: got %h want 1040", rpc); end
        n_cmp++; if (rbr !== 1'b1) begin n_bad++; $display("FAIL br_br_v: got %b want 1", rbr); end
        n_cmp++; if ({rtk, rntk, rnb} !== 3'b100) begin n_bad++; $display("FAIL br_quals: got %b want 100", {rtk, rntk, rnb}); end
        n_cmp++; if (rmd !== 16'h0AB1) begin n_bad++; $display("FAIL br_md: got %h want 0ab1", rmd); end
        n_cmp++; if (mis_cnt !== 32'd1) begin n_bad++; $display("FAIL br_mis_cnt: got %0d want 1", mis_cnt); end
        n_cmp++; if (av !== 1'b0) begin n_bad++; $display("FAIL br_no_attaboy: got %b want 0", av); end
        step();
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL br_pulse_end: got %b want 0", rv); end
        // not-taken mispredicted branch
        drive(va_t'(32'h1100), va_t'(32'h1104), va_t'(32'h1180), 1'b0, 16'h0001);
        step();
        idle();
        n_cmp++; if ({rv, rbr, rtk, rntk, rnb} !== 5'b11010) begin n_bad++; $display("FAIL br_nt_quals: got %b want 11010", {rv, rbr, rtk, rntk, rnb}); end
        n_cmp++; if (mis_cnt !== 32'd2) begin n_bad++; $display("FAIL br_nt_mis_cnt: got %0d want 2", mis_cnt); end
        step();
    endtask

    task automatic test_nonbr();
        drive(va_t'(32'h2000), va_t'(32'h2004), va_t'(32'h2100), 1'b0, 16'h0008);
        step();
        idle();
        n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL nonbr_v: got %b want 1", rv); end
        n_cmp++; if (rpc !== va_t'(32'h2004)) begin n_bad++; $display("FAIL nonbr_pc: got %h want 2004", rpc); end
        n_cmp++; if ({rbr, rtk, rntk, rnb} !== 4'b1001) begin n_bad++; $display("FAIL nonbr_quals: got %b want 1001", {rbr, rtk, rntk, rnb}); end
        n_cmp++; if (mis_cnt !== 32'd3) begin n_bad++; $display("FAIL nonbr_mis_cnt: got %0d want 3", mis_cnt); end
        n_cmp++; if (s_mis_cnt !== 2'd3) begin n_bad++; $display("FAIL nonbr_sat_mis: got %0d want 3", s_mis_cnt); end
        step();
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL nonbr_pulse_end: got %b want 0", rv); end
        // fourth mispredict: narrow counter must hold at all-ones
        drive(va_t'(32'h2200), va_t'(32'h2204), va_t'(32'h2300), 1'b0, 16'h0008);
        step();
        idle();
        n_cmp++; if (s_mis_cnt !== 2'd3) begin n_bad++; $display("FAIL mis_saturate: got %0d want 3", s_mis_cnt); end
        n_cmp++; if (mis_cnt !== 32'd4) begin n_bad++; $display("FAIL mis_cnt4: got %0d want 4", mis_cnt); end
        step();
    endtask

    task automatic test_none();
        drive(va_t'(32'h2004), va_t'(32'h2008), va_t'(32'h2008), 1'b0, 16'h0000);
        step();
        idle();
        n_cmp++; if ({rv, av} !== 2'b00) begin n_bad++; $display("FAIL none_outputs: got %b want 00", {rv, av}); end
        n_cmp++; if (mis_cnt !== 32'd4) begin n_bad++; $display("FAIL none_mis_cnt: got %0d want 4", mis_cnt); end
        n_cmp++; if (atb_cnt !== 32'd0) begin n_bad++; $display("FAIL none_atb_cnt: got %0d want 0", atb_cnt); end
    endtask

    task automatic test_queue_full();
        va_t  npc [5];
        md_t  md  [5];
        logic tk  [5];
        logic ntk [5];
        npc[0] = va_t'(32'h3000); md[0] = 16'h0002; tk[0] = 1'b1; ntk[0] = 1'b0;
        npc[1] = va_t'(32'h3104); md[1] = 16'h0011; tk[1] = 1'b0; ntk[1] = 1'b1;
        npc[2] = va_t'(32'h3200); md[2] = 16'h0024; tk[2] = 1'b1; ntk[2] = 1'b0;
        npc[3] = va_t'(32'h3300); md[3] = 16'h0032; tk[3] = 1'b1; ntk[3] = 1'b0;
        npc[4] = va_t'(32'h3400); md[4] = 16'h0042; tk[4] = 1'b1; ntk[4] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(va_t'(32'h0F00 + i * 4), npc[i], npc[i], tk[i], md[i]);
            n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL qf_ready_%0d: got %b want 1", i, ready); end
            step();
        end
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL qf_full_ready: got %b want 0", ready); end
        n_cmp++; if (atb_cnt !== 32'd4) begin n_bad++; $display("FAIL qf_atb4: got %0d want 4", atb_cnt); end
        n_cmp++; if (apc !== npc[0]) begin n_bad++; $display("FAIL qf_head0: got %h want %h", apc, npc[0]); end
        drive(va_t'(32'h0F10), npc[4], npc[4], tk[4], md[4]);
        step();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL qf_still_full: got %b want 0", ready); end
        n_cmp++; if (atb_cnt !== 32'd4) begin n_bad++; $display("FAIL qf_no_enq: got %0d want 4", atb_cnt); end
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL qf_no_redirect: got %b want 0", rv); end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL qf_space: got %b want 1", ready); end
        n_cmp++; if (atb_cnt !== 32'd4) begin n_bad++; $display("FAIL qf_full_yumi_cnt: got %0d want 4", atb_cnt); end
        step();
        idle();
        n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL qf_refull: got %b want 0", ready); end
        n_cmp++; if (atb_cnt !== 32'd5) begin n_bad++; $display("FAIL qf_atb5: got %0d want 5", atb_cnt); end
        n_cmp++; if (s_atb_cnt !== 2'd3) begin n_bad++; $display("FAIL atb_saturate: got %0d want 3", s_atb_cnt); end
        for (int k = 1; k < 5; k++) begin
            n_cmp++; if (av !== 1'b1) begin n_bad++; $display("FAIL qf_drain_v_%0d: got %b want 1", k, av); end
            n_cmp++; if (apc !== npc[k]) begin n_bad++; $display("FAIL qf_drain_pc_%0d: got %h want %h", k, apc, npc[k]); end
            n_cmp++; if (amd !== md[k]) begin n_bad++; $display("FAIL qf_drain_md_%0d: got %h want %h", k, amd, md[k]); end
            n_cmp++; if ({atk, antk} !== {tk[k], ntk[k]}) begin n_bad++; $display("FAIL qf_drain_tk_%0d: got %b want %b", k, {atk, antk}, {tk[k], ntk[k]}); end
            yumi = 1'b1;
            step();
            yumi = 1'b0;
        end
        n_cmp++; if ({av, ready} !== 2'b01) begin n_bad++; $display("FAIL qf_empty: got %b want 01", {av, ready}); end
    endtask

    task automatic test_trap();
        drive(va_t'(32'h3F00), va_t'(32'h4000), va_t'(32'h4000), 1'b0, 16'h0002);
        step();
        idle();
        drive(va_t'(32'h5000), va_t'(32'h5040), va_t'(32'h5004), 1'b1, 16'h0001);
        trap_v = 1'b1;
        trap_pc = va_t'(32'h8000_0000);
        step();
        idle();
        n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL trap_v: got %b want 1", rv); end
        n_cmp++; if (rpc !== va_t'(32'h8000_0000)) begin n_bad++; $display("FAIL trap_pc: got %h want 80000000", rpc); end
        n_cmp++; if ({rbr, rtk, rntk, rnb} !== 4'b0000) begin n_bad++; $display("FAIL trap_quals: got %b want 0000", {rbr, rtk, rntk, rnb}); end
        n_cmp++; if (mis_cnt !== 32'd4) begin n_bad++; $display("FAIL trap_mis_cnt: got %0d want 4", mis_cnt); end
        n_cmp++; if (atb_cnt !== 32'd6) begin n_bad++; $display("FAIL trap_atb_cnt: got %0d want 6", atb_cnt); end
        n_cmp++; if ({av, apc} !== {1'b1, va_t'(32'h4000)}) begin n_bad++; $display("FAIL trap_keeps_queue: got %b/%h want 1/4000", av, apc); end
        step();
        n_cmp++; if (rv !== 1'b0) begin n_bad++; $display("FAIL trap_pulse_end: got %b want 0", rv); end
        yumi = 1'b1;
        step();
        yumi = 1'b0;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(va_t'(32'h5F00), va_t'(32'h6000 + i * 4), va_t'(32'h6000 + i * 4), 1'b0, 16'h0002);
            step();
        end
        drive(va_t'(32'h6100), va_t'(32'h6140), va_t'(32'h6104), 1'b1, 16'h0001);
        step();
        idle();
        n_cmp++; if ({rv, av} !== 2'b11) begin n_bad++; $display("FAIL rm_pre: got %b want 11", {rv, av}); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({rv, av, ready} !== 3'b001) begin n_bad++; $display("FAIL rm_async: got %b want 001", {rv, av, ready}); end
        step();
        n_cmp++; if ({rv, av, ready} !== 3'b001) begin n_bad++; $display("FAIL rm_outputs: got %b want 001", {rv, av, ready}); end
        n_cmp++; if ({mis_cnt, atb_cnt} !== 64'd0) begin n_bad++; $display("FAIL rm_counters: got %0d/%0d want 0/0", mis_cnt, atb_cnt); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        drive(va_t'(32'h6F00), va_t'(32'h7000), va_t'(32'h7000), 1'b0, 16'h0002);
        #1;
        n_cmp++; if (av !== 1'b0) begin n_bad++; $display("FAIL b2b_no_bypass: got %b want 0", av); end
        step();
        for (int k = 1; k < 20; k++) begin
            drive(va_t'(32'h6F00), va_t'(32'h7000 + k * 4), va_t'(32'h7000 + k * 4), 1'b0, 16'h0002);
            yumi = 1'b1;
            n_cmp++; if ({av, apc} !== {1'b1, va_t'(32'h7000 + (k - 1) * 4)}) begin n_bad++; $display("FAIL b2b_head_%0d: got %b/%h want 1/%h", k, av, apc, 32'h7000 + (k - 1) * 4); end
            step();
        end
        idle();
        yumi = 1'b1;
        n_cmp++; if (apc !== va_t'(32'h704C)) begin n_bad++; $display("FAIL b2b_last: got %h want 704c", apc); end
        step();
        yumi = 1'b0;
        n_cmp++; if ({av, ready} !== 2'b01) begin n_bad++; $display("FAIL b2b_empty: got %b want 01", {av, ready}); end
        n_cmp++; if (atb_cnt !== 32'd20) begin n_bad++; $display("FAIL b2b_atb_cnt: got %0d want 20", atb_cnt); end
        n_cmp++; if (s_atb_cnt !== 2'd3) begin n_bad++; $display("FAIL b2b_sat: got %0d want 3", s_atb_cnt); end
    endtask

    initial begin
        test_reset();
        test_br_redirect();
        test_nonbr();
        test_none();
        test_queue_full();
        test_trap();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
